// File: rtl/alu_seq_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : alu_seq_pkg
// Purpose : Shared definitions for the sequential ALU: the full 16-entry CPU
//           opcode map, the flag-register bit indices and the FSM state type.
// Ports   : none (package)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package alu_seq_pkg;

    // Original eight opcodes of the 4-bit CPU ALU
    localparam logic [3:0] OP_AND   = 4'h0;
    localparam logic [3:0] OP_OR    = 4'h1;
    localparam logic [3:0] OP_XOR   = 4'h2;
    localparam logic [3:0] OP_NOT_A = 4'h3;
    localparam logic [3:0] OP_INC_A = 4'h4;
    localparam logic [3:0] OP_DEC_A = 4'h5;
    localparam logic [3:0] OP_SHL_A = 4'h6;
    localparam logic [3:0] OP_SHR_A = 4'h7;
    // Carry-chained arithmetic
    localparam logic [3:0] OP_ADD   = 4'h8;
    localparam logic [3:0] OP_SUB   = 4'h9;
    localparam logic [3:0] OP_ADC   = 4'hA;
    localparam logic [3:0] OP_SBC   = 4'hB;
    // Iterative multi-bit shifts; they occupy the whole 4'b11xx quadrant
    localparam logic [3:0] OP_SHL_N = 4'hC;
    localparam logic [3:0] OP_SHR_N = 4'hD;
    localparam logic [3:0] OP_ASR_N = 4'hE;
    localparam logic [3:0] OP_ROL_N = 4'hF;

    // Bit positions in the CPU flag register
    localparam int FLAG_Z    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_N    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // True for the opcodes that run through the one-bit-per-cycle shifter
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op[3:2] == 2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : alu_seq_if
// Purpose : Request/response bundle between the CPU core and alu_seq.
// Ports   : master drives start/opcode/a/b/shamt and observes ready, c,
//           zf/cf/nf/vf and done; slave is the ALU side.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic             start;
    logic             ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] c;
    logic             zf;
    logic             cf;
    logic             nf;
    logic             vf;
    logic             done;

    modport master (
        output start, opcode, a, b, shamt,
        input  ready, c, zf, cf, nf, vf, done
    );

    modport slave (
        input  start, opcode, a, b, shamt,
        output ready, c, zf, cf, nf, vf, done
    );

endinterface
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : alu_comb
// Purpose : Combinational WIDTH-bit datapath. Computes every single-cycle
//           operation and, for the iterative opcodes, exactly one shift step
//           of operand a.
// Ports   : op   - operation code
//           a, b - operands (a is the work value for a shift step)
//           cin  - stored carry flag, consumed by ADC/SBC
//           res  - result
//           cout - carry / borrow / bit shifted or rotated out
//           vout - signed overflow (arithmetic ops only)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module alu_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic [3:0]       op,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             cin,
    output logic      [WIDTH-1:0] res,
    output logic                  cout,
    output logic                  vout
);

    localparam int MSB = WIDTH - 1;

    // One guard bit above the datapath catches carry out / borrow
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_ext_a;
    logic [WIDTH:0] w_ext_b;
    logic [WIDTH:0] w_ext_cin;
    logic [WIDTH:0] w_ext_one;

    assign w_ext_a   = {1'b0, a};
    assign w_ext_b   = {1'b0, b};
    assign w_ext_cin = {{WIDTH{1'b0}}, cin};
    assign w_ext_one = {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_sum = '0;
        res   = '0;
        cout  = 1'b0;
        vout  = 1'b0;
        case (op)
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_NOT_A: res = ~a;
            OP_INC_A: begin
                w_sum = w_ext_a + w_ext_one;
                res   = w_sum[MSB:0];
                cout  = w_sum[WIDTH];
                vout  = ~a[MSB] & res[MSB];
            end
            OP_DEC_A: begin
                // Borrow out of the guard bit is set exactly when a == 0
                w_sum = w_ext_a - w_ext_one;
                res   = w_sum[MSB:0];
                cout  = w_sum[WIDTH];
                vout  = a[MSB] & ~res[MSB];
            end
            OP_SHL_A: begin
                res  = {a[MSB-1:0], 1'b0};
                cout = a[MSB];
            end
            OP_SHR_A: begin
                res  = {1'b0, a[MSB:1]};
                cout = a[0];
            end
            OP_ADD, OP_ADC: begin
                w_sum = w_ext_a + w_ext_b + ((op == OP_ADC) ? w_ext_cin : '0);
                res   = w_sum[MSB:0];
                cout  = w_sum[WIDTH];
                vout  = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBC: begin
                w_sum = w_ext_a - w_ext_b - ((op == OP_SBC) ? w_ext_cin : '0);
                res   = w_sum[MSB:0];
                cout  = w_sum[WIDTH];
                vout  = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
            end
            // Single step of the iterative shifter
            OP_SHL_N: begin
                res  = {a[MSB-1:0], 1'b0};
                cout = a[MSB];
            end
            OP_SHR_N: begin
                res  = {1'b0, a[MSB:1]};
                cout = a[0];
            end
            OP_ASR_N: begin
                res  = {a[MSB], a[MSB:1]};
                cout = a[0];
            end
            OP_ROL_N: begin
                // The reported bit is the one that lands in the LSB
                res  = {a[MSB-1:0], a[MSB]};
                cout = a[MSB];
            end
            default: begin
                res  = '0;
                cout = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : alu_seq
// Purpose : Registered WIDTH-bit ALU with carry chaining through the stored
//           carry flag and an iterative one-bit-per-cycle shift/rotate unit.
//           Single-cycle ops complete on the accept edge; *_N ops with n > 1
//           continue in SHIFT for n-1 further edges.
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous active-high reset
//           bus   - alu_seq_if slave: start/ready handshake, opcode, a, b,
//                   shamt in; c, zf, cf, nf, vf and done pulse out
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_seq_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_op;
    logic [3:0]           w_op_nxt;
    logic [WIDTH-1:0]     r_work;
    logic [WIDTH-1:0]     w_work_nxt;
    logic [SHW-1:0]       r_count;
    logic [SHW-1:0]       w_count_nxt;
    logic [WIDTH-1:0]     r_c;
    logic [WIDTH-1:0]     w_c_nxt;
    logic [NUM_FLAGS-1:0] r_flags;
    logic [NUM_FLAGS-1:0] w_flags_nxt;
    logic                 r_done;
    logic                 w_done_nxt;

    logic                 w_accept;
    logic [3:0]           w_alu_op;
    logic [WIDTH-1:0]     w_alu_a;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_cout;
    logic                 w_alu_vout;

    function automatic logic [NUM_FLAGS-1:0] mk_flags(
        input logic [WIDTH-1:0] res,
        input logic             carry,
        input logic             ovf
    );
        logic [NUM_FLAGS-1:0] f;
        f         = '0;
        f[FLAG_Z] = (res == '0);
        f[FLAG_C] = carry;
        f[FLAG_N] = res[WIDTH-1];
        f[FLAG_V] = ovf;
        return f;
    endfunction

    assign w_accept = bus.start && (r_state == ST_IDLE);

    // One datapath instance serves both the accept edge (fresh operands)
    // and every later shift step (stored op and work register).
    assign w_alu_op = (r_state == ST_SHIFT) ? r_op   : bus.opcode;
    assign w_alu_a  = (r_state == ST_SHIFT) ? r_work : bus.a;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .op   (w_alu_op),
        .a    (w_alu_a),
        .b    (bus.b),
        .cin  (r_flags[FLAG_C]),
        .res  (w_alu_res),
        .cout (w_alu_cout),
        .vout (w_alu_vout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_work  <= '0;
            r_count <= '0;
            r_c     <= '0;
            r_flags <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_work  <= w_work_nxt;
            r_count <= w_count_nxt;
            r_c     <= w_c_nxt;
            r_flags <= w_flags_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_work_nxt  = r_work;
        w_count_nxt = r_count;
        w_c_nxt     = r_c;
        w_flags_nxt = r_flags;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (is_iter_op(bus.opcode) && (bus.shamt == '0)) begin
                        // Zero-length shift passes a straight through
                        w_c_nxt     = bus.a;
                        w_flags_nxt = mk_flags(bus.a, 1'b0, 1'b0);
                        w_done_nxt  = 1'b1;
                    end else if (is_iter_op(bus.opcode) &&
                                 (bus.shamt != SHW'(1))) begin
                        // Step 1 happens now; n-1 steps remain
                        w_work_nxt  = w_alu_res;
                        w_count_nxt = bus.shamt - SHW'(1);
                        w_op_nxt    = bus.opcode;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_c_nxt     = w_alu_res;
                        w_flags_nxt = mk_flags(w_alu_res, w_alu_cout, w_alu_vout);
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                w_work_nxt  = w_alu_res;
                w_count_nxt = r_count - SHW'(1);
                if (r_count == SHW'(1)) begin
                    w_c_nxt     = w_alu_res;
                    w_flags_nxt = mk_flags(w_alu_res, w_alu_cout, w_alu_vout);
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.ready = (r_state == ST_IDLE);
    assign bus.c     = r_c;
    assign bus.zf    = r_flags[FLAG_Z];
    assign bus.cf    = r_flags[FLAG_C];
    assign bus.nf    = r_flags[FLAG_N];
    assign bus.vf    = r_flags[FLAG_V];
    assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_alu_seq
// Purpose : Self-checking bench for alu_seq (WIDTH = 8). A vector table feeds
//           a scoreboard queue; a monitor pops and compares on every done.
//           Hand-written sequences cover latency, ignored start and abort.
// Ports   : none
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int NVEC  = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // f packs the expected flags as {zf, cf, nf, vf}
    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sh;
        logic [7:0] c;
        logic [3:0] f;
    } vec_t;

    typedef struct {
        logic [7:0] c;
        logic [3:0] f;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] sh);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.a      = a;
        bus.b      = b;
        bus.shamt  = sh;
    endtask

    // Called at a negedge; waits (bounded) for ready, issues for one edge.
    task automatic issue(input vec_t v);
        int guard;
        guard = 0;
        while (bus.ready !== 1'b1 && guard < 50) begin
            bus.start = 1'b0;
            @(negedge clk);
            guard++;
        end
        if (bus.ready !== 1'b1) begin
            chk("ready_timeout", {31'd0, bus.ready}, 32'd1);
            return;
        end
        drive(v.op, v.a, v.b, v.sh);
        sb.push_back('{v.c, v.f});
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: actual done=1 with nothing pending, required done=0 at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("result_c", {24'd0, bus.c}, {24'd0, mon_e.c});
                chk("flags_zcnv", {28'd0, bus.zf, bus.cf, bus.nf, bus.vf}, {28'd0, mon_e.f});
            end
        end
    end

    initial begin
        vec_t vecs[NVEC];
        int   lowcnt;
        int   guard;

        bus.start  = 1'b0;
        bus.opcode = '0;
        bus.a      = '0;
        bus.b      = '0;
        bus.shamt  = '0;
        reset      = 1'b1;

        //            op        a      b      sh    c      {z,c,n,v}
        vecs[0]  = '{OP_ADD,   8'hFF, 8'h01, 3'd0, 8'h00, 4'b1100};
        vecs[1]  = '{OP_ADC,   8'h01, 8'h01, 3'd0, 8'h03, 4'b0000};
        vecs[2]  = '{OP_ADD,   8'h7F, 8'h01, 3'd0, 8'h80, 4'b0011};
        vecs[3]  = '{OP_SUB,   8'h00, 8'h01, 3'd0, 8'hFF, 4'b0110};
        vecs[4]  = '{OP_DEC_A, 8'h80, 8'h00, 3'd0, 8'h7F, 4'b0001};
        vecs[5]  = '{OP_SHR_N, 8'h05, 8'h00, 3'd3, 8'h00, 4'b1100};
        vecs[6]  = '{OP_ASR_N, 8'h80, 8'h00, 3'd7, 8'hFF, 4'b0010};
        vecs[7]  = '{OP_SHL_N, 8'h5A, 8'h00, 3'd0, 8'h5A, 4'b0000};
        vecs[8]  = '{OP_AND,   8'hF0, 8'h3C, 3'd0, 8'h30, 4'b0000};
        vecs[9]  = '{OP_OR,    8'hF0, 8'h0F, 3'd0, 8'hFF, 4'b0010};
        vecs[10] = '{OP_XOR,   8'hAA, 8'hAA, 3'd0, 8'h00, 4'b1000};
        vecs[11] = '{OP_NOT_A, 8'h0F, 8'h00, 3'd0, 8'hF0, 4'b0010};
        vecs[12] = '{OP_INC_A, 8'hFF, 8'h00, 3'd0, 8'h00, 4'b1100};
        vecs[13] = '{OP_SHL_A, 8'h81, 8'h00, 3'd0, 8'h02, 4'b0100};
        vecs[14] = '{OP_SHR_A, 8'h81, 8'h00, 3'd0, 8'h40, 4'b0100};
        vecs[15] = '{OP_SBC,   8'h10, 8'h05, 3'd0, 8'h0A, 4'b0000};
        vecs[16] = '{OP_ROL_N, 8'h81, 8'h00, 3'd1, 8'h03, 4'b0100};
        vecs[17] = '{OP_ROL_N, 8'h81, 8'h00, 3'd7, 8'hC0, 4'b0010};
        vecs[18] = '{OP_SHL_N, 8'h81, 8'h00, 3'd5, 8'h20, 4'b0000};
        vecs[19] = '{OP_ADC,   8'hFF, 8'h00, 3'd0, 8'hFF, 4'b0010};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_c", {24'd0, bus.c}, 32'd0);
        chk("reset_flags", {28'd0, bus.zf, bus.cf, bus.nf, bus.vf}, 32'd0);
        chk("reset_ready", {31'd0, bus.ready}, 32'd1);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table, issued back-to-back whenever the ALU is ready
        for (int i = 0; i < NVEC; i++) issue(vecs[i]);
        bus.start = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("table_drained", sb.size(), 32'd0);

        // Asynchronous reset mid-cycle clears outputs at once
        #2 reset = 1'b1;
        #1;
        chk("async_reset_c", {24'd0, bus.c}, 32'd0);
        chk("async_reset_flags", {28'd0, bus.zf, bus.cf, bus.nf, bus.vf}, 32'd0);
        chk("async_reset_ready", {31'd0, bus.ready}, 32'd1);
        chk("async_reset_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // SHR_N n=3: ready low for two cycles, done on edge accept+2
        drive(OP_SHR_N, 8'h05, 8'h00, 3'd3);
        sb.push_back('{8'h00, 4'b1100});
        @(negedge clk);
        bus.start = 1'b0;
        lowcnt = 0;
        guard  = 0;
        while (bus.done !== 1'b1 && guard < 20) begin
            if (bus.ready === 1'b0) lowcnt++;
            @(negedge clk);
            guard++;
        end
        chk("shr_n_done_seen", {31'd0, bus.done}, 32'd1);
        chk("shr_n_ready_low_cycles", lowcnt, 32'd2);
        chk("shr_n_ready_at_done", {31'd0, bus.ready}, 32'd1);

        // SHL_N n=0 is single-cycle
        drive(OP_SHL_N, 8'h5A, 8'h00, 3'd0);
        sb.push_back('{8'h5A, 4'b0000});
        @(negedge clk);
        bus.start = 1'b0;
        chk("shl_n0_done_next_cycle", {31'd0, bus.done}, 32'd1);
        chk("shl_n0_ready_stays", {31'd0, bus.ready}, 32'd1);

        // SHL_N n=5 with start held high throughout SHIFT, final edge included
        drive(OP_SHL_N, 8'h81, 8'h00, 3'd5);
        sb.push_back('{8'h20, 4'b0000});
        @(negedge clk);
        drive(OP_ADD, 8'h11, 8'h22, 3'd0);
        guard = 0;
        while (bus.done !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b0;
        chk("shl_n5_done_seen", {31'd0, bus.done}, 32'd1);
        repeat (4) @(negedge clk);
        chk("ignored_start_nothing_pending", sb.size(), 32'd0);
        chk("c_held_after_shift", {24'd0, bus.c}, 32'h20);

        // Same shift aborted by reset before step 3: no done pulse
        drive(OP_SHL_N, 8'h81, 8'h00, 3'd5);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_c", {24'd0, bus.c}, 32'd0);
        chk("abort_flags", {28'd0, bus.zf, bus.cf, bus.nf, bus.vf}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("after_abort_ready", {31'd0, bus.ready}, 32'd1);
        chk("after_abort_c", {24'd0, bus.c}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
